// File: rtl/instruction_fetch.sv
// Fetch stage: one memory read per PC value, responses buffered with their PC for decode.
// Optional build macro FETCH_STATS_EN adds stat_fetched/stat_flushed counters.
module instruction_fetch #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              pc_advance,
    input  logic              flush,
    output logic              imem_req_valid,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    input  logic              if_ready
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]       stat_fetched,
    output logic [31:0]       stat_flushed
`endif
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DROP
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pend_pc;
    logic [ADDR_W-1:0] r_fifo_pc    [FIFO_DEPTH];
    logic [DATA_W-1:0] r_fifo_instr [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_full;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;

    assign w_full = (r_count == CNT_W'(FIFO_DEPTH));

    // Flush wins over everything: suppresses the request and any push this cycle.
    always_comb begin
        w_state_nxt    = r_state;
        imem_req_valid = 1'b0;
        imem_req_addr  = '0;
        w_accept       = 1'b0;
        w_push         = 1'b0;
        case (r_state)
            IDLE: w_state_nxt = REQ;
            REQ: begin
                imem_req_addr  = pc_in;
                imem_req_valid = !w_full && !flush;
                w_accept       = imem_req_valid && imem_req_ready;
                if (w_accept) w_state_nxt = WAIT;
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    w_push      = !flush;
                    w_state_nxt = REQ;
                end else if (flush) begin
                    w_state_nxt = DROP;
                end
            end
            DROP: if (imem_rsp_valid) w_state_nxt = REQ;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign pc_advance = w_accept;
    assign if_valid   = (r_count != '0);
    assign if_instr   = r_fifo_instr[r_rd_ptr];
    assign if_pc      = r_fifo_pc[r_rd_ptr];
    assign w_pop      = if_valid && if_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_pend_pc <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) r_pend_pc <= pc_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fifo_pc    <= '{default: '0};
            r_fifo_instr <= '{default: '0};
        end else if (w_push) begin
            r_fifo_pc[r_wr_ptr]    <= r_pend_pc;
            r_fifo_instr[r_wr_ptr] <= imem_rsp_data;
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] r_stat_fetched;
    logic [31:0] r_stat_flushed;
    logic        w_inflight;

    // Only a WAIT-state fetch is still live; a DROP fetch was already counted.
    assign w_inflight = (r_state == WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_fetched <= '0;
            r_stat_flushed <= '0;
        end else begin
            if (w_pop) r_stat_fetched <= r_stat_fetched + 32'd1;
            if (flush) r_stat_flushed <= r_stat_flushed + 32'(r_count) + 32'(w_inflight);
        end
    end

    assign stat_fetched = r_stat_fetched;
    assign stat_flushed = r_stat_flushed;
`endif

endmodule
